// File: rtl/csync_timing_ctrl.sv
// Composite-sync timing recovery: separates hsync/vsync, regenerates line starts,
// measures line period and lines per frame, and tracks lock to a stable frame rate.
module csync_timing_ctrl #(
    parameter int unsigned VS_THRESH = 80,
    parameter int unsigned LINE_MAX  = 414,
    parameter int unsigned MIN_LINES = 200,
    parameter int unsigned MAX_LINES = 400
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_2pix,
    input  logic       csync,
    output logic       line_start,
    output logic       frame_start,
    output logic       buf_toggle,
    output logic [9:0] line_cnt,
    output logic [9:0] line_period,
    output logic [9:0] lines_per_frame,
    output logic       pal,
    output logic       locked
);
    localparam logic [7:0] VS_T     = 8'(VS_THRESH);
    localparam logic [9:0] COL_LAST = 10'(LINE_MAX - 1);
    localparam logic [9:0] MIN_L    = 10'(MIN_LINES);
    localparam logic [9:0] MAX_L    = 10'(MAX_LINES);
    localparam logic [9:0] PAL_L    = 10'd288;

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    state_t     state_q, state_d;
    logic       csd_q, csd_d;
    logic [7:0] sync_len_q, sync_len_d;
    logic [9:0] col_cnt_q, col_cnt_d;
    logic [9:0] line_cnt_q, line_cnt_d;
    logic [9:0] line_period_q, line_period_d;
    logic [9:0] lpf_q, lpf_d;
    logic       buf_toggle_q, buf_toggle_d;
    logic       line_start_q, line_start_d;
    logic       frame_start_q, frame_start_d;
    logic       rise, fs, ls;

    always_comb begin
        rise = csync & ~csd_q;
        fs   = ce_2pix & ~csync & (sync_len_q == VS_T);
        // A rising edge ending a vsync is not a line boundary; the column
        // timeout keeps lines flowing through vsync and missing hsyncs.
        ls   = ce_2pix & ((rise & (sync_len_q < VS_T)) | (col_cnt_q == COL_LAST));

        state_d       = state_q;
        csd_d         = csd_q;
        sync_len_d    = sync_len_q;
        col_cnt_d     = col_cnt_q;
        line_cnt_d    = line_cnt_q;
        line_period_d = line_period_q;
        lpf_d         = lpf_q;
        buf_toggle_d  = buf_toggle_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (ce_2pix) begin
            csd_d         = csync;
            line_start_d  = ls;
            frame_start_d = fs;

            if (csync)
                sync_len_d = '0;
            else if (sync_len_q != '1)
                sync_len_d = sync_len_q + 8'd1;

            if (ls) begin
                col_cnt_d     = '0;
                line_period_d = (col_cnt_q == '1) ? col_cnt_q : col_cnt_q + 10'd1;
                buf_toggle_d  = ~buf_toggle_q;
            end else if (col_cnt_q != '1) begin
                col_cnt_d = col_cnt_q + 10'd1;
            end

            if (fs)
                line_cnt_d = '0;
            else if (ls && line_cnt_q != '1)
                line_cnt_d = line_cnt_q + 10'd1;

            case (state_q)
                SEARCH: if (fs) state_d = MEASURE;
                MEASURE, LOCKED: begin
                    if (fs) begin
                        if (line_cnt_q >= MIN_L && line_cnt_q <= MAX_L) begin
                            state_d = LOCKED;
                            lpf_d   = line_cnt_q;
                        end else begin
                            state_d = SEARCH;
                        end
                    end else if (line_cnt_q > MAX_L) begin
                        state_d = SEARCH;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= SEARCH;
            csd_q         <= 1'b0;
            sync_len_q    <= '0;
            col_cnt_q     <= '0;
            line_cnt_q    <= '0;
            line_period_q <= '0;
            lpf_q         <= '0;
            buf_toggle_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            csd_q         <= csd_d;
            sync_len_q    <= sync_len_d;
            col_cnt_q     <= col_cnt_d;
            line_cnt_q    <= line_cnt_d;
            line_period_q <= line_period_d;
            lpf_q         <= lpf_d;
            buf_toggle_q  <= buf_toggle_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign line_start      = line_start_q;
    assign frame_start     = frame_start_q;
    assign buf_toggle      = buf_toggle_q;
    assign line_cnt        = line_cnt_q;
    assign line_period     = line_period_q;
    assign lines_per_frame = lpf_q;
    assign pal             = (lpf_q >= PAL_L);
    assign locked          = (state_q == LOCKED);
endmodule

// File: tb/tb_csync_timing_ctrl.sv
// Directed bench for csync_timing_ctrl with shortened lines (16 ticks) and vsync
// threshold so whole frames of 150..405 lines fit in a short run.
module tb_csync_timing_ctrl;
    localparam int unsigned VS   = 10;
    localparam int unsigned LM   = 16;
    localparam int unsigned MINL = 200;
    localparam int unsigned MAXL = 400;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce_2pix = 1'b0;
    logic       csync = 1'b1;
    logic       line_start, frame_start, buf_toggle, pal, locked;
    logic [9:0] line_cnt, line_period, lines_per_frame;

    int checks = 0;
    int errors = 0;
    int fs_count = 0;
    int ls_count = 0;
    int tick_no = 0;
    int last_ls_tick = 0;
    int ls_gap = 0;
    bit gap_en = 1'b0;

    always #5 clk = ~clk;

    csync_timing_ctrl #(
        .VS_THRESH(VS),
        .LINE_MAX (LM),
        .MIN_LINES(MINL),
        .MAX_LINES(MAXL)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ce_2pix        (ce_2pix),
        .csync          (csync),
        .line_start     (line_start),
        .frame_start    (frame_start),
        .buf_toggle     (buf_toggle),
        .line_cnt       (line_cnt),
        .line_period    (line_period),
        .lines_per_frame(lines_per_frame),
        .pal            (pal),
        .locked         (locked)
    );

    // One ce tick; registered outputs for that tick are visible #1 after the edge.
    // With gap_en an idle clk (ce low, csync inverted) follows and must change nothing.
    task automatic step(input logic cs);
        logic [32:0] held;
        ce_2pix = 1'b1;
        csync   = cs;
        @(posedge clk); #1;
        tick_no++;
        if (line_start === 1'b1) begin
            ls_count++;
            ls_gap = tick_no - last_ls_tick;
            last_ls_tick = tick_no;
        end
        if (frame_start === 1'b1) fs_count++;
        if (gap_en) begin
            held = {buf_toggle, line_cnt, line_period, lines_per_frame, pal, locked};
            ce_2pix = 1'b0;
            csync   = ~cs;
            @(posedge clk); #1;
            checks++;
            if ({line_start, frame_start} !== 2'b00 ||
                {buf_toggle, line_cnt, line_period, lines_per_frame, pal, locked} !== held) begin
                errors++;
                $display("FAIL ce_gating got %h/%b want %h/00", {buf_toggle, line_cnt, line_period,
                         lines_per_frame, pal, locked}, {line_start, frame_start}, held);
            end
        end
    endtask

    task automatic send_line(input int unsigned low);
        for (int unsigned i = 0; i < LM; i++) step(i < low ? 1'b0 : 1'b1);
    endtask

    task automatic send_frame(input int unsigned n);
        send_line(12);
        for (int unsigned i = 1; i < n; i++) send_line(2);
    endtask

    task automatic test_reset;
        reset = 1'b1; ce_2pix = 1'b0; csync = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({line_start, frame_start, buf_toggle, line_cnt, line_period, lines_per_frame, pal, locked} !== '0) begin
            errors++;
            $display("FAIL reset_state got %h want 0", {line_start, frame_start, buf_toggle, line_cnt,
                     line_period, lines_per_frame, pal, locked});
        end
        reset = 1'b0;
    endtask

    task automatic test_pal;
        send_line(2);
        fs_count = 0;
        send_frame(312);
        checks++;
        if (fs_count != 1) begin errors++; $display("FAIL pal_fs1 got %0d want 1", fs_count); end
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL pal_measure_locked got %b want 0", locked); end
        checks++;
        if (line_cnt !== 10'd311) begin errors++; $display("FAIL pal_line_cnt got %0d want 311", line_cnt); end
        send_frame(312);
        checks++;
        if (fs_count != 2) begin errors++; $display("FAIL pal_fs2 got %0d want 2", fs_count); end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL pal_locked got %b want 1", locked); end
        checks++;
        if (lines_per_frame !== 10'd312) begin errors++; $display("FAIL pal_lpf got %0d want 312", lines_per_frame); end
        checks++;
        if (pal !== 1'b1) begin errors++; $display("FAIL pal_flag got %b want 1", pal); end
        checks++;
        if (line_period !== 10'(LM)) begin errors++; $display("FAIL pal_period got %0d want %0d", line_period, LM); end
    endtask

    task automatic test_ntsc;
        gap_en = 1'b1;
        send_frame(262);
        checks++;
        if (lines_per_frame !== 10'd312) begin errors++; $display("FAIL ntsc_lpf_first got %0d want 312", lines_per_frame); end
        send_frame(262);
        gap_en = 1'b0;
        checks++;
        if (lines_per_frame !== 10'd262) begin errors++; $display("FAIL ntsc_lpf got %0d want 262", lines_per_frame); end
        checks++;
        if (pal !== 1'b0) begin errors++; $display("FAIL ntsc_pal got %b want 0", pal); end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL ntsc_locked got %b want 1", locked); end
        checks++;
        if (fs_count != 4) begin errors++; $display("FAIL ntsc_fs got %0d want 4", fs_count); end
    endtask

    task automatic test_free_run;
        logic prev_bt;
        int   start_ls;
        prev_bt  = buf_toggle;
        start_ls = ls_count;
        for (int unsigned i = 0; i < 2000; i++) begin
            step(1'b1);
            if (line_start === 1'b1) begin
                checks++;
                if (ls_gap != int'(LM) || buf_toggle === prev_bt) begin
                    errors++;
                    $display("FAIL free_run_pulse got gap %0d bt %b want gap %0d bt %b", ls_gap, buf_toggle, LM, ~prev_bt);
                end
                prev_bt = buf_toggle;
            end
        end
        checks++;
        if (ls_count - start_ls != 125) begin errors++; $display("FAIL free_run_count got %0d want 125", ls_count - start_ls); end
        checks++;
        if (line_period !== 10'(LM)) begin errors++; $display("FAIL free_run_period got %0d want %0d", line_period, LM); end
    endtask

    task automatic test_hsync_loss;
        send_line(12);
        test_free_run();
        for (int unsigned i = 0; i < 275; i++) send_line(0);
        checks++;
        if (line_cnt !== 10'd400) begin errors++; $display("FAIL loss_cnt400 got %0d want 400", line_cnt); end
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL loss_at400_locked got %b want 1", locked); end
        send_line(0);
        checks++;
        if (line_cnt !== 10'd401) begin errors++; $display("FAIL loss_cnt401 got %0d want 401", line_cnt); end
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL loss_locked got %b want 0", locked); end
        checks++;
        if (lines_per_frame !== 10'd262) begin errors++; $display("FAIL loss_lpf got %0d want 262", lines_per_frame); end
    endtask

    task automatic test_short_frame;
        send_frame(312);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL short_measure got %b want 0", locked); end
        send_frame(150);
        checks++;
        if (locked !== 1'b1 || lines_per_frame !== 10'd312) begin
            errors++; $display("FAIL short_relock got %b/%0d want 1/312", locked, lines_per_frame);
        end
        send_line(12);
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL short_locked got %b want 0", locked); end
        checks++;
        if (lines_per_frame !== 10'd312 || pal !== 1'b1) begin
            errors++; $display("FAIL short_lpf got %0d/%b want 312/1", lines_per_frame, pal);
        end
    endtask

    task automatic test_reset_midframe;
        for (int unsigned i = 1; i < 312; i++) send_line(2);
        send_frame(312);
        send_frame(100);
        checks++;
        if (locked !== 1'b1 || line_cnt !== 10'd99) begin
            errors++; $display("FAIL midrst_pre got %b/%0d want 1/99", locked, line_cnt);
        end
        reset = 1'b1; ce_2pix = 1'b1; csync = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({line_start, frame_start, buf_toggle, line_cnt, line_period, lines_per_frame, pal, locked} !== '0) begin
            errors++;
            $display("FAIL midrst_zero got %h want 0", {line_start, frame_start, buf_toggle, line_cnt,
                     line_period, lines_per_frame, pal, locked});
        end
        reset = 1'b0;
        for (int unsigned i = 0; i < 212; i++) send_line(2);
        send_frame(312);
        checks++;
        if (locked !== 1'b0 || lines_per_frame !== 10'd0) begin
            errors++; $display("FAIL midrst_measure got %b/%0d want 0/0", locked, lines_per_frame);
        end
        send_frame(312);
        checks++;
        if (locked !== 1'b1 || lines_per_frame !== 10'd312 || pal !== 1'b1) begin
            errors++; $display("FAIL midrst_relock got %b/%0d/%b want 1/312/1", locked, lines_per_frame, pal);
        end
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_pal();
        test_ntsc();
        test_hsync_loss();
        test_short_frame();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
